// File: rtl/vid_pkg.sv
// Shared video definitions used by the timing generator and the overlay stage.
//   rgb_t        : 24-bit packed pixel, R[23:16] G[15:8] B[7:0]
//   VB/HB        : bit positions inside vh_blank  ({Vblank, Hblank})
//   DS/VS/HS     : bit positions inside dvh_sync  ({D_sync, Vsync, Hsync})
//   *_1080P      : 1080p60 raster timing
//   BAR_RGB      : colour-bar palette, left to right
package vid_pkg;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb_t;

    localparam int VB = 1;
    localparam int HB = 0;
    localparam int DS = 2;
    localparam int VS = 1;
    localparam int HS = 0;

    localparam int H_ACTIVE_1080P = 1920;
    localparam int H_FP_1080P     = 88;
    localparam int H_SYNC_1080P   = 44;
    localparam int H_BP_1080P     = 148;
    localparam int V_ACTIVE_1080P = 1080;
    localparam int V_FP_1080P     = 4;
    localparam int V_SYNC_1080P   = 5;
    localparam int V_BP_1080P     = 36;

    localparam rgb_t BAR_RGB [8] = '{
        rgb_t'(24'hFFFFFF), rgb_t'(24'hFFFF00), rgb_t'(24'h00FFFF), rgb_t'(24'h00FF00),
        rgb_t'(24'hFF00FF), rgb_t'(24'hFF0000), rgb_t'(24'h0000FF), rgb_t'(24'h000000)
    };

endpackage

// File: rtl/vtg_counter.sv
// Wrap counter used for both the horizontal and the vertical position.
//   clk_i  : clock
//   rst_i  : synchronous active-high reset, clears the count
//   en_i   : advance by one (or wrap) on this edge
//   cnt_o  : current count, 0..MAX
//   wrap_o : high while en_i is high and the count is at MAX, i.e. this
//            edge wraps the counter back to 0
module vtg_counter #(
    parameter int MAX = 2199,
    parameter int W   = 12
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         en_i,
    output logic [W-1:0] cnt_o,
    output logic         wrap_o
);

    logic [W-1:0] cnt_reg;

    assign cnt_o  = cnt_reg;
    assign wrap_o = en_i && (cnt_reg == W'(MAX));

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_reg <= '0;
        end else if (en_i) begin
            cnt_reg <= wrap_o ? '0 : cnt_reg + 1'b1;
        end
    end

endmodule

// File: rtl/video_timing_gen.sv
// Raster timing and test-pattern source (1080p60 by default).
// Every output is registered and mutually aligned: on an enabled edge where
// the counters hold (h,v) the outputs load pixel (h,v) while the counters move on.
//   clk_i        : pixel clock
//   rst_i        : synchronous active-high reset (wins over cen_i)
//   cen_i        : pixel enable; nothing advances while low
//   pat_sel_i    : 0 = colour bars, 1 = solid_rgb_i
//   solid_rgb_i  : solid colour, R[23:16] G[15:8] B[7:0]
//   vid_rgb_o    : pixel colour, black outside the active area
//   vh_blank_o   : {Vblank, Hblank}
//   dvh_sync_o   : {D_sync, Vsync, Hsync}; sync polarity set by SYNC_POL
//   pix_x_o/y_o  : position of the pixel on the outputs
//   sof_o        : high for output pixel (0,0)
// Build option: define VTG_BORDER_EN to force the outermost active rows and
// columns to white for edge-alignment checks.
module video_timing_gen
    import vid_pkg::*;
#(
    parameter int H_ACTIVE = H_ACTIVE_1080P,
    parameter int H_FP     = H_FP_1080P,
    parameter int H_SYNC   = H_SYNC_1080P,
    parameter int H_BP     = H_BP_1080P,
    parameter int V_ACTIVE = V_ACTIVE_1080P,
    parameter int V_FP     = V_FP_1080P,
    parameter int V_SYNC   = V_SYNC_1080P,
    parameter int V_BP     = V_BP_1080P,
    parameter int SYNC_POL = 1
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        cen_i,
    input  logic        pat_sel_i,
    input  logic [23:0] solid_rgb_i,
    output logic [23:0] vid_rgb_o,
    output logic [1:0]  vh_blank_o,
    output logic [2:0]  dvh_sync_o,
    output logic [11:0] pix_x_o,
    output logic [11:0] pix_y_o,
    output logic        sof_o
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int BAR_W   = H_ACTIVE / 8;

    localparam logic [11:0] H_ACT_END  = 12'(H_ACTIVE);
    localparam logic [11:0] H_SYNC_BEG = 12'(H_ACTIVE + H_FP);
    localparam logic [11:0] H_SYNC_END = 12'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [11:0] V_ACT_END  = 12'(V_ACTIVE);
    localparam logic [11:0] V_SYNC_BEG = 12'(V_ACTIVE + V_FP);
    localparam logic [11:0] V_SYNC_END = 12'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [11:0] BAR_LAST   = 12'(BAR_W - 1);
    localparam logic        POL        = (SYNC_POL != 0);

    logic [11:0] h_cnt;
    logic [11:0] v_cnt;
    logic        h_wrap;
    logic        v_wrap;

    vtg_counter #(.MAX(H_TOTAL - 1), .W(12)) u_h_cnt (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .en_i   (cen_i),
        .cnt_o  (h_cnt),
        .wrap_o (h_wrap)
    );

    vtg_counter #(.MAX(V_TOTAL - 1), .W(12)) u_v_cnt (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .en_i   (h_wrap),
        .cnt_o  (v_cnt),
        .wrap_o (v_wrap)
    );

    // Bar index tracks h_cnt without a divider: sub counter runs 0..BAR_W-1,
    // then bumps the 3-bit index. Both sit at 0 whenever h_cnt is 0.
    logic [2:0]  bar_idx_reg;
    logic [11:0] bar_sub_reg;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            bar_idx_reg <= '0;
            bar_sub_reg <= '0;
        end else if (cen_i) begin
            if (h_wrap) begin
                bar_idx_reg <= '0;
                bar_sub_reg <= '0;
            end else if (bar_sub_reg == BAR_LAST) begin
                bar_idx_reg <= bar_idx_reg + 3'd1;
                bar_sub_reg <= '0;
            end else begin
                bar_sub_reg <= bar_sub_reg + 12'd1;
            end
        end
    end

    // Counters only ever reach (0,0) through reset or a full-frame wrap,
    // so this flag marks the start-of-frame pixel without a 24-bit compare.
    logic frame_start_reg;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            frame_start_reg <= 1'b1;
        end else if (cen_i) begin
            frame_start_reg <= v_wrap;
        end
    end

    logic hblank;
    logic vblank;
    logic de;
    logic hs_act;
    logic vs_act;

    assign hblank = (h_cnt >= H_ACT_END);
    assign vblank = (v_cnt >= V_ACT_END);
    assign de     = ~hblank & ~vblank;
    assign hs_act = (h_cnt >= H_SYNC_BEG) && (h_cnt < H_SYNC_END);
    assign vs_act = (v_cnt >= V_SYNC_BEG) && (v_cnt < V_SYNC_END);

    rgb_t       rgb_next;
    logic [1:0] vh_next;
    logic [2:0] dvh_next;

    always_comb begin
        rgb_next = pat_sel_i ? rgb_t'(solid_rgb_i) : BAR_RGB[bar_idx_reg];
`ifdef VTG_BORDER_EN
        if ((h_cnt == 12'd0) || (h_cnt == H_ACT_END - 12'd1) ||
            (v_cnt == 12'd0) || (v_cnt == V_ACT_END - 12'd1)) begin
            rgb_next = rgb_t'(24'hFFFFFF);
        end
`endif
        if (!de) begin
            rgb_next = '0;
        end

        vh_next     = '0;
        vh_next[VB] = vblank;
        vh_next[HB] = hblank;

        dvh_next     = '0;
        dvh_next[DS] = de;
        dvh_next[VS] = vs_act ~^ POL;
        dvh_next[HS] = hs_act ~^ POL;
    end

    logic [23:0] rgb_reg;
    logic [1:0]  vh_reg;
    logic [2:0]  dvh_reg;
    logic [11:0] x_reg;
    logic [11:0] y_reg;
    logic        sof_reg;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rgb_reg     <= '0;
            vh_reg      <= 2'b11;
            dvh_reg     <= '0;
            dvh_reg[VS] <= ~POL;
            dvh_reg[HS] <= ~POL;
            x_reg       <= '0;
            y_reg       <= '0;
            sof_reg     <= 1'b0;
        end else if (cen_i) begin
            rgb_reg <= rgb_next;
            vh_reg  <= vh_next;
            dvh_reg <= dvh_next;
            x_reg   <= h_cnt;
            y_reg   <= v_cnt;
            sof_reg <= frame_start_reg;
        end
    end

    assign vid_rgb_o  = rgb_reg;
    assign vh_blank_o = vh_reg;
    assign dvh_sync_o = dvh_reg;
    assign pix_x_o    = x_reg;
    assign pix_y_o    = y_reg;
    assign sof_o      = sof_reg;

endmodule

// File: tb/tb_video_timing_gen.sv
// Scoreboard bench for video_timing_gen on a reduced raster so whole frames
// fit in a short run. Two instances share stimulus: one with active-high
// sync, one with active-low sync.
//   Raster: H = 32 active + 4 fp + 3 sync + 5 bp = 44, bar width 4
//           V =  6 active + 2 fp + 2 sync + 2 bp = 12, frame = 528 pixels
module tb_video_timing_gen;

    localparam int HA = 32, HFP = 4, HSY = 3, HBP = 5;
    localparam int VA = 6,  VFP = 2, VSY = 2, VBP = 2;
    localparam int HT = HA + HFP + HSY + HBP;
    localparam int VT = VA + VFP + VSY + VBP;

    typedef struct packed {
        logic [23:0] rgb;
        logic [1:0]  vhb;
        logic [2:0]  dvh_p;
        logic [2:0]  dvh_n;
        logic [11:0] x;
        logic [11:0] y;
        logic        sof;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cen = 1'b0;
    logic        pat_sel = 1'b0;
    logic [23:0] solid = 24'h000000;

    logic [23:0] rgb_p, rgb_n;
    logic [1:0]  vhb_p, vhb_n;
    logic [2:0]  dvh_p, dvh_n;
    logic [11:0] x_p, y_p, x_n, y_n;
    logic        sof_p, sof_n;

    always #5 clk = ~clk;

    video_timing_gen #(
        .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSY), .H_BP(HBP),
        .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSY), .V_BP(VBP), .SYNC_POL(1)
    ) dut_p (
        .clk_i(clk), .rst_i(rst), .cen_i(cen), .pat_sel_i(pat_sel),
        .solid_rgb_i(solid), .vid_rgb_o(rgb_p), .vh_blank_o(vhb_p),
        .dvh_sync_o(dvh_p), .pix_x_o(x_p), .pix_y_o(y_p), .sof_o(sof_p)
    );

    video_timing_gen #(
        .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSY), .H_BP(HBP),
        .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSY), .V_BP(VBP), .SYNC_POL(0)
    ) dut_n (
        .clk_i(clk), .rst_i(rst), .cen_i(cen), .pat_sel_i(pat_sel),
        .solid_rgb_i(solid), .vid_rgb_o(rgb_n), .vh_blank_o(vhb_n),
        .dvh_sync_o(dvh_n), .pix_x_o(x_n), .pix_y_o(y_n), .sof_o(sof_n)
    );

    int n_total = 0;
    int n_pass  = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        n_total++;
        if (got === want) n_pass++;
        else $display("FAIL %s: got %h, expected %h (t=%0t)", name, got, want, $time);
    endtask

    // Expected pixel, written from the raster description.
    function automatic exp_t exp_pix(input int h, input int v, input logic p, input logic [23:0] s);
        logic [23:0] bars [8];
        exp_t e;
        logic hb, vb, de, hs, vs;
        bars = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                 24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};
        hb = (h >= HA);
        vb = (v >= VA);
        de = !hb && !vb;
        hs = (h >= HA + HFP) && (h < HA + HFP + HSY);
        vs = (v >= VA + VFP) && (v < VA + VFP + VSY);
        e.rgb = 24'h0;
        if (de) begin
            e.rgb = p ? s : bars[h / (HA / 8)];
`ifdef VTG_BORDER_EN
            if (h == 0 || h == HA - 1 || v == 0 || v == VA - 1) e.rgb = 24'hFFFFFF;
`endif
        end
        e.vhb   = {vb, hb};
        e.dvh_p = {de, vs, hs};
        e.dvh_n = {de, ~vs, ~hs};
        e.x     = 12'(h);
        e.y     = 12'(v);
        e.sof   = (h == 0) && (v == 0);
        return e;
    endfunction

    function automatic exp_t reset_exp();
        exp_t e;
        e.rgb = 24'h0; e.vhb = 2'b11; e.dvh_p = 3'b000; e.dvh_n = 3'b011;
        e.x = 12'd0; e.y = 12'd0; e.sof = 1'b0;
        return e;
    endfunction

    exp_t q[$];
    exp_t last_e;
    int   m_h = 0, m_v = 0;      // position the counters hold
    int   out_h = -1, out_v = -1; // pixel loaded by the latest enabled edge
    logic cur_pat = 1'b0;
    logic [23:0] cur_solid = 24'h0;
    logic out_new = 1'b0;

    // One clock of stimulus: drive at the negedge and push what the outputs
    // must show after the following posedge.
    task automatic drive(input logic c, input logic r);
        exp_t e;
        @(negedge clk);
        cen = c; rst = r; pat_sel = cur_pat; solid = cur_solid;
        out_new = 1'b0;
        if (r) begin
            e = reset_exp();
            m_h = 0; m_v = 0; out_h = -1; out_v = -1;
        end else if (c) begin
            e = exp_pix(m_h, m_v, cur_pat, cur_solid);
            out_h = m_h; out_v = m_v; out_new = 1'b1;
            if (m_h == HT - 1) begin
                m_h = 0;
                m_v = (m_v == VT - 1) ? 0 : m_v + 1;
            end else begin
                m_h = m_h + 1;
            end
        end else begin
            e = last_e;
        end
        last_e = e;
        q.push_back(e);
    endtask

    task automatic settle();
        @(posedge clk);
        #2;
    endtask

    // Monitor: one expected entry per clock once stimulus starts.
    int   en_cnt = 0;
    logic have_sof = 1'b0;
    always @(posedge clk) begin
        logic c_s, r_s;
        exp_t e;
        c_s = cen; r_s = rst;
        #1;
        if (q.size() > 0) begin
            e = q.pop_front();
            check("rgb",     32'(rgb_p), 32'(e.rgb));
            check("rgb_n",   32'(rgb_n), 32'(e.rgb));
            check("vh_blank", 32'(vhb_p), 32'(e.vhb));
            check("dvh_pos", 32'(dvh_p), 32'(e.dvh_p));
            check("dvh_neg", 32'(dvh_n), 32'(e.dvh_n));
            check("pix_xy",  {8'h0, x_p, y_p}, {8'h0, e.x, e.y});
            check("sof",     32'(sof_p), 32'(e.sof));
            if (r_s) begin
                have_sof = 1'b0;
                en_cnt   = 0;
            end else if (c_s) begin
                en_cnt++;
                if (sof_p) begin
                    if (have_sof) check("sof_period", 32'(en_cnt), 32'(HT * VT));
                    have_sof = 1'b1;
                    en_cnt   = 0;
                end
            end
        end
    end

    initial begin
        last_e = reset_exp();

        // Reset, including reset together with enable.
        drive(1'b0, 1'b1);
        drive(1'b1, 1'b1);
        drive(1'b0, 1'b1);

        // Continuous enable, colour bars, one full frame plus a line.
        for (int i = 0; i < HT * VT + HT + 10; i++) begin
            drive(1'b1, 1'b0);
            if (out_h == 0 && out_v == 0 && i == 0) begin
                settle();
                check("first_sof", 32'(sof_p), 32'd1);
                check("first_de",  32'(dvh_p[2]), 32'd1);
                check("first_rgb", 32'(rgb_p), 32'hFFFFFF);
            end else if (out_v == 0 && out_h == 4) begin
                settle();
                check("bar1_rgb", 32'(rgb_p), 32'hFFFF00);
            end else if (out_v == 0 && out_h == 28) begin
                settle();
                check("bar7_rgb", 32'(rgb_p), 32'h000000);
            end else if (out_v == 0 && out_h == HA) begin
                settle();
                check("hblank_rise", 32'(vhb_p), 32'h1);
            end else if (out_v == 0 && out_h == HA + HFP) begin
                settle();
                check("hsync_neg_low", 32'(dvh_n[0]), 32'd0);
            end else if (out_v == VA + VFP && out_h == 0) begin
                settle();
                check("vsync_line", 32'(dvh_p), 32'b010);
            end
        end

        // Enable pattern 1,0,0,1.
        for (int i = 0; i < 200; i++) begin
            drive((i % 4 == 0) || (i % 4 == 3), 1'b0);
        end

        // Run to a mid-frame position, then reset.
        for (int i = 0; i < HT * VT && !(m_h == 20 && m_v == 3); i++) drive(1'b1, 1'b0);
        check("reached_mid", 32'(m_h * 100 + m_v), 32'(20 * 100 + 3));
        drive(1'b0, 1'b1);
        settle();
        check("mid_rst_blank", 32'(vhb_p), 32'b11);
        check("mid_rst_dvh_n", 32'(dvh_n), 32'b011);
        drive(1'b0, 1'b0);
        drive(1'b1, 1'b0);
        settle();
        check("post_rst_sof", 32'(sof_p), 32'd1);
        check("post_rst_xy",  {8'h0, x_p, y_p}, 32'h0);

        // Solid colour with irregular enable.
        cur_pat   = 1'b1;
        cur_solid = 24'h123456;
        for (int i = 0; i < 1300; i++) begin
            drive($urandom_range(0, 2) != 0, 1'b0);
            if (out_new && out_v == 5 && out_h == 1) begin
                settle();
`ifdef VTG_BORDER_EN
                check("solid_1_5", 32'(rgb_p), 32'hFFFFFF);
`else
                check("solid_1_5", 32'(rgb_p), 32'h123456);
`endif
            end else if (out_new && out_v == 5 && out_h == 0) begin
                settle();
`ifdef VTG_BORDER_EN
                check("solid_0_5", 32'(rgb_p), 32'hFFFFFF);
`else
                check("solid_0_5", 32'(rgb_p), 32'h123456);
`endif
            end
        end

        drive(1'b0, 1'b0);
        drive(1'b0, 1'b0);
        repeat (2) @(posedge clk);
        #3;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
